// File: rtl/microsequencer_n.sv
// Microcode address sequencer: cond jump/call/ret, loop counter, dispatch, sticky stack errors.
// New address 1 cycle after op; stall=1 freezes pc, stack, counter and flags.
module microsequencer_n #(
   parameter int ADDR_WIDTH  = 12,
   parameter int STACK_DEPTH = 4,
   parameter int COUNT_WIDTH = 8,
   parameter int NUM_COND    = 8
) (
   input  logic                        clock,
   input  logic                        reset,
   input  logic [2:0]                  op,
   input  logic [$clog2(NUM_COND)-1:0] cond_sel,
   input  logic                        cond_invert,
   input  logic [NUM_COND-1:0]         cond_in,
   input  logic [ADDR_WIDTH-1:0]       d_in,
   input  logic [ADDR_WIDTH-1:0]       dispatch_in,
   input  logic                        stall,
   output logic [ADDR_WIDTH-1:0]       address,
   output logic                        count_zero,
   output logic                        stack_empty,
   output logic                        stack_full,
   output logic                        overflow,
   output logic                        underflow
);

   localparam int SPW  = $clog2(STACK_DEPTH + 1);
   localparam int IDXW = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;

   localparam logic [2:0] OP_NEXT     = 3'd0;
   localparam logic [2:0] OP_JUMP     = 3'd1;
   localparam logic [2:0] OP_CALL     = 3'd2;
   localparam logic [2:0] OP_RET      = 3'd3;
   localparam logic [2:0] OP_LDCNT    = 3'd4;
   localparam logic [2:0] OP_LOOP     = 3'd5;
   localparam logic [2:0] OP_DISPATCH = 3'd6;
   localparam logic [2:0] OP_HOLD     = 3'd7;

   logic [ADDR_WIDTH-1:0]  pc_q, pc_d;
   logic [SPW-1:0]         sp_q, sp_d;
   logic [COUNT_WIDTH-1:0] cnt_q, cnt_d;
   logic                   ovf_q, ovf_d;
   logic                   unf_q, unf_d;

   logic [ADDR_WIDTH-1:0]  stack_q [0:(2**IDXW)-1];
   logic                   push_we;

   logic [ADDR_WIDTH-1:0]  inc;
   logic [SPW-1:0]         sp_m1;
   logic                   cond;
   logic                   full;
   logic                   empty;

   assign inc   = pc_q + ADDR_WIDTH'(1);
   assign sp_m1 = sp_q - SPW'(1);
   assign full  = (sp_q == SPW'(STACK_DEPTH));
   assign empty = (sp_q == '0);
   assign cond  = ((cond_sel == '0) ? 1'b1 : cond_in[cond_sel]) ^ cond_invert;

   always_comb begin
      pc_d    = pc_q;
      sp_d    = sp_q;
      cnt_d   = cnt_q;
      ovf_d   = ovf_q;
      unf_d   = unf_q;
      push_we = 1'b0;
      if (!stall) begin
         pc_d = inc;
         case (op)
            OP_NEXT: pc_d = inc;
            OP_JUMP: begin
               if (cond) pc_d = d_in;
            end
            OP_CALL: begin
               if (cond) begin
                  // The target is taken even when the return address has to be dropped.
                  pc_d = d_in;
                  if (full) begin
                     ovf_d = 1'b1;
                  end else begin
                     push_we = 1'b1;
                     sp_d    = sp_q + SPW'(1);
                  end
               end
            end
            OP_RET: begin
               if (cond) begin
                  if (empty) begin
                     unf_d = 1'b1;
                  end else begin
                     pc_d = stack_q[sp_m1[IDXW-1:0]];
                     sp_d = sp_m1;
                  end
               end
            end
            OP_LDCNT: cnt_d = d_in[COUNT_WIDTH-1:0];
            OP_LOOP: begin
               if (cnt_q != '0) begin
                  cnt_d = cnt_q - COUNT_WIDTH'(1);
                  pc_d  = d_in;
               end
            end
            OP_DISPATCH: pc_d = dispatch_in;
            OP_HOLD:     pc_d = pc_q;
            default:     pc_d = inc;
         endcase
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         pc_q  <= '0;
         sp_q  <= '0;
         cnt_q <= '0;
         ovf_q <= 1'b0;
         unf_q <= 1'b0;
      end else begin
         pc_q  <= pc_d;
         sp_q  <= sp_d;
         cnt_q <= cnt_d;
         ovf_q <= ovf_d;
         unf_q <= unf_d;
      end
   end

   // Stack contents need no reset; sp alone decides what is valid.
   always_ff @(posedge clock) begin
      if (push_we && !reset) stack_q[sp_q[IDXW-1:0]] <= inc;
   end

   assign address     = pc_q;
   assign count_zero  = (cnt_q == '0);
   assign stack_empty = empty;
   assign stack_full  = full;
   assign overflow    = ovf_q;
   assign underflow   = unf_q;

endmodule

// File: tb/tb_microsequencer_n.sv
// Directed bench for microsequencer_n with default parameters (12-bit address, depth-4 stack).
module tb_microsequencer_n;

   logic        clock;
   logic        reset;
   logic [2:0]  op;
   logic [2:0]  cond_sel;
   logic        cond_invert;
   logic [7:0]  cond_in;
   logic [11:0] d_in;
   logic [11:0] dispatch_in;
   logic        stall;
   logic [11:0] address;
   logic        count_zero;
   logic        stack_empty;
   logic        stack_full;
   logic        overflow;
   logic        underflow;

   int errors = 0;
   int checks = 0;

   localparam logic [2:0] NEXT = 3'd0, JUMP = 3'd1, CALL = 3'd2, RET = 3'd3,
                          LDCNT = 3'd4, LOOP = 3'd5, DISP = 3'd6;

   microsequencer_n dut (
      .clock(clock), .reset(reset), .op(op), .cond_sel(cond_sel),
      .cond_invert(cond_invert), .cond_in(cond_in), .d_in(d_in),
      .dispatch_in(dispatch_in), .stall(stall), .address(address),
      .count_zero(count_zero), .stack_empty(stack_empty), .stack_full(stack_full),
      .overflow(overflow), .underflow(underflow)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Present one op, let one rising edge pass, and return 1 time unit later.
   task automatic step(input logic [2:0] o, input logic [11:0] d);
      op   = o;
      d_in = d;
      @(posedge clock);
      #1;
   endtask

   initial begin
      reset = 1'b1; op = NEXT; cond_sel = 3'd0; cond_invert = 1'b0;
      cond_in = 8'h00; d_in = 12'h000; dispatch_in = 12'h000; stall = 1'b0;
      #12;
      chk("rst_addr", {20'h0, address}, 32'h0);
      chk("rst_cz", {31'h0, count_zero}, 32'h1);
      chk("rst_empty", {31'h0, stack_empty}, 32'h1);
      chk("rst_full", {31'h0, stack_full}, 32'h0);
      chk("rst_flags", {30'h0, overflow, underflow}, 32'h0);
      @(negedge clock);
      reset = 1'b0;

      // NEXT sweep, then async reset mid-count
      step(NEXT, 12'h000); chk("next1", {20'h0, address}, 32'h1);
      step(NEXT, 12'h000); chk("next2", {20'h0, address}, 32'h2);
      step(NEXT, 12'h000); chk("next3", {20'h0, address}, 32'h3);
      reset = 1'b1;
      #2;
      chk("async_rst", {20'h0, address}, 32'h0);
      reset = 1'b0;
      step(NEXT, 12'h000); chk("next_after_rst", {20'h0, address}, 32'h1);

      // wrap of all-ones to zero
      step(JUMP, 12'hFFE); chk("jump_ffe", {20'h0, address}, 32'hFFE);
      step(NEXT, 12'h000); chk("wrap_fff", {20'h0, address}, 32'hFFF);
      step(NEXT, 12'h000); chk("wrap_000", {20'h0, address}, 32'h000);

      // conditional jump
      cond_in = 8'b0000_0100; cond_sel = 3'd2; cond_invert = 1'b0;
      step(JUMP, 12'h0A0); chk("jmp_taken", {20'h0, address}, 32'h0A0);
      cond_invert = 1'b1;
      step(JUMP, 12'h0A0); chk("jmp_inv", {20'h0, address}, 32'h0A1);
      cond_sel = 3'd0;
      step(JUMP, 12'h055); chk("jmp_never", {20'h0, address}, 32'h0A2);
      cond_sel = 3'd3; cond_invert = 1'b0;
      step(JUMP, 12'h055); chk("jmp_false", {20'h0, address}, 32'h0A3);
      cond_sel = 3'd0;

      // nested call/return
      step(JUMP, 12'h010); chk("to_010", {20'h0, address}, 32'h010);
      step(CALL, 12'h100); chk("call1", {20'h0, address}, 32'h100);
      chk("call1_nonempty", {31'h0, stack_empty}, 32'h0);
      step(NEXT, 12'h000); chk("at_101", {20'h0, address}, 32'h101);
      step(CALL, 12'h200); chk("call2", {20'h0, address}, 32'h200);
      step(RET, 12'h000);  chk("ret1", {20'h0, address}, 32'h102);
      step(RET, 12'h000);  chk("ret2", {20'h0, address}, 32'h011);
      chk("nest_empty", {31'h0, stack_empty}, 32'h1);
      chk("nest_flags", {30'h0, overflow, underflow}, 32'h0);
      cond_invert = 1'b1;
      step(CALL, 12'h300); chk("call_false", {20'h0, address}, 32'h012);
      chk("call_false_empty", {31'h0, stack_empty}, 32'h1);
      step(RET, 12'h000);  chk("ret_false", {20'h0, address}, 32'h013);
      chk("ret_false_unf", {31'h0, underflow}, 32'h0);
      cond_invert = 1'b0;

      // stack overflow / underflow
      step(JUMP, 12'h040); chk("to_040", {20'h0, address}, 32'h040);
      for (int i = 0; i < 4; i++) begin
         step(CALL, 12'h050);
         chk("fill_call", {20'h0, address}, 32'h050);
      end
      chk("full_4", {31'h0, stack_full}, 32'h1);
      chk("full_no_ovf", {31'h0, overflow}, 32'h0);
      step(CALL, 12'h060); chk("call5_jump", {20'h0, address}, 32'h060);
      chk("call5_full", {31'h0, stack_full}, 32'h1);
      chk("call5_ovf", {31'h0, overflow}, 32'h1);
      step(RET, 12'h000); chk("pop4", {20'h0, address}, 32'h051);
      chk("pop4_notfull", {31'h0, stack_full}, 32'h0);
      step(RET, 12'h000); chk("pop3", {20'h0, address}, 32'h051);
      step(RET, 12'h000); chk("pop2", {20'h0, address}, 32'h051);
      step(RET, 12'h000); chk("pop1", {20'h0, address}, 32'h041);
      chk("pop_empty", {31'h0, stack_empty}, 32'h1);
      chk("pop_no_unf", {31'h0, underflow}, 32'h0);
      step(RET, 12'h000); chk("pop5_inc", {20'h0, address}, 32'h042);
      chk("pop5_unf", {31'h0, underflow}, 32'h1);
      step(NEXT, 12'h000); chk("sticky", {30'h0, overflow, underflow}, 32'h3);
      reset = 1'b1;
      #2;
      chk("flags_rst", {30'h0, overflow, underflow}, 32'h0);
      reset = 1'b0;

      // loop counter
      step(JUMP, 12'h020);  chk("to_020", {20'h0, address}, 32'h020);
      step(LDCNT, 12'h003); chk("ldcnt", {20'h0, address}, 32'h021);
      chk("ldcnt_cz", {31'h0, count_zero}, 32'h0);
      for (int i = 0; i < 4; i++) begin
         step(NEXT, 12'h000); chk("loop_body_end", {20'h0, address}, 32'h022);
         step(LOOP, 12'h021);
         if (i < 3) chk("loop_back", {20'h0, address}, 32'h021);
         else       chk("loop_exit", {20'h0, address}, 32'h023);
      end
      chk("loop_cz", {31'h0, count_zero}, 32'h1);

      // dispatch and stall
      dispatch_in = 12'h03B;
      step(DISP, 12'h000); chk("dispatch", {20'h0, address}, 32'h03B);
      stall = 1'b1;
      for (int i = 0; i < 5; i++) begin
         step(CALL, 12'h070);
         chk("stall_addr", {20'h0, address}, 32'h03B);
         chk("stall_stack", {31'h0, stack_empty}, 32'h1);
         chk("stall_flags", {30'h0, overflow, underflow}, 32'h0);
      end
      stall = 1'b0;
      step(CALL, 12'h070); chk("stall_release", {20'h0, address}, 32'h070);
      chk("release_push", {31'h0, stack_empty}, 32'h0);
      step(NEXT, 12'h000); chk("after_call", {20'h0, address}, 32'h071);
      step(RET, 12'h000);  chk("single_push_ret", {20'h0, address}, 32'h03C);
      chk("single_push_empty", {31'h0, stack_empty}, 32'h1);
      chk("final_flags", {30'h0, overflow, underflow}, 32'h0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
